// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner_if
//  Purpose  : Button pin and conditioned-output bundle between the pin side
//             and the UI consumers.
//  Revision : 1.0  initial release
// ============================================================================
interface button_conditioner_if;
    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;

    // master: whoever drives the pin and consumes the conditioned signals
    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    // slave: the conditioner itself
    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronises and debounces a bouncing push-button; emits press,
//             release and long-press pulses.
//  Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 100000
) (
    input  wire logic               clk,
    input  wire logic               reset,
    button_conditioner_if.slave     btn
);

    localparam int c_db_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_hold_w = $clog2(LONG_CYCLES + 1);

    localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0]   c_db_one    = c_db_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_zero = '0;

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_pressed   = 2'd1;
    localparam logic [1:0] c_long_held = 2'd2;

    logic                r_sync1;
    logic                r_sync2;
    logic [c_db_w-1:0]   r_db_cnt;
    logic                r_level;
    logic [1:0]          r_state;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_press;
    logic                r_release;
    logic                r_long;

    logic                w_differ;
    logic                w_flip;
    logic                w_rise;
    logic                w_fall;
    logic [1:0]          w_state_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic                w_press_nxt;
    logic                w_release_nxt;
    logic                w_long_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn.btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The level flips on the edge whose increment would reach DEBOUNCE_CYCLES,
    // so the counter itself never holds that value.
    assign w_differ = (r_sync2 != r_level);
    assign w_flip   = w_differ && (r_db_cnt == c_db_last);
    assign w_rise   = w_flip && !r_level;
    assign w_fall   = w_flip &&  r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (w_flip) begin
            r_db_cnt <= '0;
            r_level  <= ~r_level;
        end else if (w_differ) begin
            r_db_cnt <= r_db_cnt + c_db_one;
        end else begin
            r_db_cnt <= '0;
        end
    end

    // Pulses are decided from the same flip condition as the level, so each
    // pulse lands in the first cycle the new level is visible.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_rise) begin
                    w_state_nxt = c_pressed;
                    w_hold_nxt  = c_hold_zero;
                    w_press_nxt = 1'b1;
                end
            end
            c_pressed: begin
                // A fall on the would-be long edge takes priority over btn_long.
                if (w_fall) begin
                    w_state_nxt   = c_idle;
                    w_hold_nxt    = c_hold_zero;
                    w_release_nxt = 1'b1;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = c_long_held;
                    w_hold_nxt  = r_hold_cnt + c_hold_one;
                    w_long_nxt  = 1'b1;
                end else begin
                    w_hold_nxt  = r_hold_cnt + c_hold_one;
                end
            end
            c_long_held: begin
                if (w_fall) begin
                    w_state_nxt   = c_idle;
                    w_hold_nxt    = c_hold_zero;
                    w_release_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_hold_nxt  = c_hold_zero;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_hold_cnt <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
        end
    end

    assign btn.btn_level   = r_level;
    assign btn.btn_press   = r_press;
    assign btn.btn_release = r_release;
    assign btn.btn_long    = r_long;

    a_pulses_exclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({r_press, r_release, r_long}));

    a_press_with_level: assert property (@(posedge clk) disable iff (reset)
        r_press |-> r_level);

    a_release_without_level: assert property (@(posedge clk) disable iff (reset)
        r_release |-> !r_level);

    a_long_with_level: assert property (@(posedge clk) disable iff (reset)
        r_long |-> r_level);

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions a raw, asynchronous, bouncing watch push-button into clean signals for the backlight controller and other UI consumers.
- Sits directly upstream of backlight_controller. btn_press drives its btn_backlight input.
- Provides:
  - two-flop synchronisation
  - a debounced level
  - single-cycle press and release pulses
  - a single-cycle long-press pulse

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive clk cycles the synchronised input must differ from the debounced state before that state flips. Must be at least 1.
- LONG_CYCLES, 100000, clk cycles the debounced level must stay high, after its rise, before btn_long fires. Must be at least 1.
- Internal counter widths are $clog2(param+1). Counters never wrap.

Ports:
- clk  input  1  system clock; all registers are updated on its rising edge
- reset  input  1  asynchronous, active-high reset
- btn_raw  input  1  raw button pin; asynchronous to clk; 1 = pressed
- btn_level  output  1  debounced, synchronised button state
- btn_press  output  1  one-cycle pulse when btn_level rises
- btn_release  output  1  one-cycle pulse when btn_level falls
- btn_long  output  1  one-cycle pulse when the button has been held for LONG_CYCLES cycles

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - both synchroniser flops = 0
  - debounce counter = 0
  - hold counter = 0
  - FSM = IDLE
  - all outputs = 0
- Synchroniser: sync1 <= btn_raw; sync2 <= sync1. Only sync2 is used downstream.
- Debounce counter:
  - Each edge where sync2 != btn_level: counter increments.
  - When the increment would reach DEBOUNCE_CYCLES: btn_level toggles and the counter clears.
  - Any edge where sync2 == btn_level: counter clears.
  - Result: a glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- Latency: let edge k be the first edge that samples btn_raw high, with btn_raw held high afterwards. btn_level rises at edge k+DEBOUNCE_CYCLES+1. Release is symmetric.
- FSM states: IDLE, PRESSED, LONG_HELD.
  - IDLE -> PRESSED on btn_level rise. btn_press = 1 in the same cycle btn_level first reads 1. Hold counter clears.
  - PRESSED: hold counter increments each edge while btn_level = 1.
  - PRESSED -> LONG_HELD when the hold counter reaches LONG_CYCLES. btn_long = 1 for exactly that one cycle, i.e. edge k+DEBOUNCE_CYCLES+1+LONG_CYCLES.
  - LONG_HELD: hold counter frozen (saturated). btn_long never re-fires while held.
  - PRESSED or LONG_HELD -> IDLE on btn_level fall. btn_release = 1 in the same cycle btn_level first reads 0. Hold counter clears.
  - A fall on the same edge the hold counter would reach LONG_CYCLES: release wins, and btn_long does not fire.
- Pulses:
  - btn_press, btn_release and btn_long are registered outputs, never combinational.
  - Each is high for exactly one cycle per event.
  - No two of them are ever high in the same cycle.
- Reset mid-press:
  - All outputs drop to 0 asynchronously.
  - After reset deasserts with btn_raw still high, the pin is treated as a fresh press: btn_press fires again after the normal debounce latency.
- btn_raw toggling every cycle, or every cycle up to DEBOUNCE_CYCLES-1: btn_level and all pulses stay 0 indefinitely.

Test Plan (override DEBOUNCE_CYCLES=4, LONG_CYCLES=20; clk period 2):
- Reset asserted 5 time units with btn_raw=0, then released -> all outputs 0; they stay 0 for 50 cycles.
- btn_raw high at edge k and held -> btn_level and btn_press rise at edge k+5; btn_press is low again at k+6.
- btn_raw high for exactly 3 cycles, low, repeated 10 times -> btn_level, btn_press and btn_long never assert.
- Press held 40 cycles -> btn_press at k+5; btn_long for one cycle at k+25; no second btn_long. Release -> btn_release exactly 5 edges after btn_raw is first sampled low.
- Press released so that btn_level falls 19 cycles after its rise -> btn_release fires, btn_long never fires. A second clean press afterwards produces a normal btn_press.
- Reset pulsed while held in LONG_HELD, btn_raw kept high -> outputs 0 during reset; a fresh btn_press 5 edges after the first post-reset sample; btn_long again 20 cycles later.
